// File: rtl/argmax_classifier.sv
// Streaming argmax over one logit vector per beat, one channel compared per cycle.
// Optional macro ARGMAX_SCORE_EN exposes the winning logit value as out_score.
module argmax_classifier #(
    parameter int unsigned VALUE_BITS = 18,
    parameter int unsigned CHANNELS   = 10,
    parameter int unsigned CLASS_BITS = $clog2(CHANNELS),
    parameter int unsigned COUNT_BITS = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CHANNELS-1:0][VALUE_BITS-1:0]  in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    output logic [CLASS_BITS-1:0]                out_class,
    output logic [COUNT_BITS-1:0]                out_count,
    output logic                                 out_valid,
    input  logic                                 out_ready,
`ifdef ARGMAX_SCORE_EN
    output logic signed [VALUE_BITS-1:0]         out_score,
`endif
    output logic                                 out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CLASS_BITS-1:0] LAST_IDX = CLASS_BITS'(CHANNELS - 1);

    state_t                               state, state_n;
    logic [CHANNELS-1:0][VALUE_BITS-1:0]  vec, vec_n;
    logic                                 last_flag, last_flag_n;
    logic [CLASS_BITS-1:0]                best_idx, best_idx_n;
    logic signed [VALUE_BITS-1:0]         best_val, best_val_n;
    logic [CLASS_BITS-1:0]                scan_idx, scan_idx_n;
    logic                                 in_ready_n;
    logic                                 out_valid_n;
    logic [COUNT_BITS-1:0]                out_count_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vec       <= '0;
            last_flag <= 1'b0;
            best_idx  <= '0;
            best_val  <= '0;
            scan_idx  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            last_flag <= last_flag_n;
            best_idx  <= best_idx_n;
            best_val  <= best_val_n;
            scan_idx  <= scan_idx_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_count <= out_count_n;
        end
    end

    // Next-state and next-output logic; handshake flags are precomputed so
    // in_ready/out_valid come straight from flops.
    always_comb begin
        state_n     = state;
        vec_n       = vec;
        last_flag_n = last_flag;
        best_idx_n  = best_idx;
        best_val_n  = best_val;
        scan_idx_n  = scan_idx;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        out_count_n = out_count;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    vec_n       = in_data;
                    last_flag_n = in_last;
                    best_idx_n  = '0;
                    best_val_n  = $signed(in_data[0]);
                    scan_idx_n  = CLASS_BITS'(1);
                    in_ready_n  = 1'b0;
                    state_n     = SCAN;
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties
                if ($signed(vec[scan_idx]) > best_val) begin
                    best_idx_n = scan_idx;
                    best_val_n = $signed(vec[scan_idx]);
                end
                scan_idx_n = scan_idx + CLASS_BITS'(1);
                if (scan_idx == LAST_IDX) begin
                    out_valid_n = 1'b1;
                    state_n     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    out_count_n = out_count + COUNT_BITS'(1);
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
            end
        endcase
    end

    assign out_class = best_idx;
    assign out_last  = last_flag;

`ifdef ARGMAX_SCORE_EN
    assign out_score = best_val;
`else
    // best_val stays internal and only feeds the comparator
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomised and directed checks of argmax_classifier against a max-then-first-index model.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_argmax_classifier;

    localparam int unsigned VB = 18;
    localparam int unsigned CH = 10;
    localparam int unsigned CB = 4;
    localparam int unsigned NB = 16;

    typedef logic [CH-1:0][VB-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset;
    vec_t          in_data;
    logic          in_valid, in_last, out_ready;
    logic          in_ready, out_valid, out_last;
    logic [CB-1:0] out_class;
    logic [NB-1:0] out_count;
    logic          in_ready2, out_valid2, out_last2;
    logic [CB-1:0] out_class2;
    logic [3:0]    out_count2;
`ifdef ARGMAX_SCORE_EN
    logic signed [VB-1:0] out_score, out_score2;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int exp_count  = 0;
    int exp_count2 = 0;

    always #5 clk = ~clk;

    argmax_classifier #(.VALUE_BITS(VB), .CHANNELS(CH), .CLASS_BITS(CB), .COUNT_BITS(NB)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .out_class(out_class), .out_count(out_count), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef ARGMAX_SCORE_EN
        .out_score(out_score),
`endif
        .out_last(out_last)
    );

    argmax_classifier #(.VALUE_BITS(VB), .CHANNELS(CH), .CLASS_BITS(CB), .COUNT_BITS(4)) dut_wrap (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .out_class(out_class2), .out_count(out_count2), .out_valid(out_valid2),
        .out_ready(out_ready),
`ifdef ARGMAX_SCORE_EN
        .out_score(out_score2),
`endif
        .out_last(out_last2)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sval(input vec_t v, input int i);
        return int'($signed(v[i]));
    endfunction

    function automatic int ref_max(input vec_t v);
        int m = sval(v, 0);
        for (int i = 1; i < CH; i++) if (sval(v, i) > m) m = sval(v, i);
        return m;
    endfunction

    // Argmax = first channel holding the maximum value
    function automatic int ref_class(input vec_t v);
        int m = ref_max(v);
        for (int i = 0; i < CH; i++) if (sval(v, i) == m) return i;
        return -1;
    endfunction

    function automatic vec_t mk(input int a[CH]);
        vec_t v;
        for (int i = 0; i < CH; i++) v[i] = VB'(a[i]);
        return v;
    endfunction

    task automatic offer(input vec_t v, input logic l);
        int n = 0;
        in_data  = v;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = vec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input vec_t v, input logic l);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, CH - 1);
        check("class", longint'(out_class), ref_class(v));
        check("last", longint'(out_last), longint'(l));
        check("count_pre", longint'(out_count), exp_count);
        check("busy_ready", longint'(in_ready), 0);
`ifdef ARGMAX_SCORE_EN
        check("score", longint'(out_score), ref_max(v));
`endif
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_count  = (exp_count + 1) % 65536;
        exp_count2 = (exp_count2 + 1) % 16;
        check("count", longint'(out_count), exp_count);
        check("count_wrap4", longint'(out_count2), exp_count2);
        check("valid_drop", longint'(out_valid), 0);
        check("ready_back", longint'(in_ready), 1);
    endtask

    task automatic run_beat(input vec_t v, input logic l);
        offer(v, l);
        wait_result(v, l);
        handshake();
    endtask

    initial begin
        int   d[CH];
        vec_t va, vb, vr;
        logic lr;
        int   seen;

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; in_data = '0;
        #2;
        check("rst_ready", longint'(in_ready), 1);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_class", longint'(out_class), 0);
        check("rst_last", longint'(out_last), 0);
        check("rst_count", longint'(out_count), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        d = '{0, 5, -3, 100, 7, 2, -50, 99, 1, 0};
        run_beat(mk(d), 1'b0);
        for (int i = 0; i < CH; i++) d[i] = -10;
        run_beat(mk(d), 1'b0);
        for (int i = 0; i < CH; i++) d[i] = (i == 2 || i == 7) ? 40 : -1;
        run_beat(mk(d), 1'b0);
        for (int i = 0; i < CH; i++) d[i] = (i == 9) ? 131071 : -131072;
        run_beat(mk(d), 1'b0);
        for (int i = 0; i < CH; i++) d[i] = -131072;
        run_beat(mk(d), 1'b1);

        // Last flag over a 3-beat stream
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < CH; i++) d[i] = int'($urandom_range(0, 200)) - 100;
            run_beat(mk(d), (k == 2));
        end

        // Backpressure with a second beat offered while blocked
        for (int i = 0; i < CH; i++) d[i] = (i == 4) ? 500 : i;
        va = mk(d);
        for (int i = 0; i < CH; i++) d[i] = (i == 6) ? 77 : -i;
        vb = mk(d);
        out_ready = 1'b0;
        offer(va, 1'b0);
        wait_result(va, 1'b0);
        in_data = vb; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("hold_valid", longint'(out_valid), 1);
            check("hold_class", longint'(out_class), ref_class(va));
            check("hold_ready", longint'(in_ready), 0);
        end
        handshake();
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("second_taken", longint'(in_ready), 0);
        wait_result(vb, 1'b1);
        handshake();

        // Randomised beats with random gaps and stalls
        for (int k = 0; k < 40; k++) begin
            int mode = int'($urandom_range(0, 3));
            int base = int'($urandom_range(0, 262143)) - 131072;
            for (int i = 0; i < CH; i++) begin
                case (mode)
                    0: d[i] = int'($urandom_range(0, 262143)) - 131072;
                    1: d[i] = int'($urandom_range(0, 6)) - 3;
                    2: case ($urandom_range(0, 3))
                           0: d[i] = -131072;
                           1: d[i] = 131071;
                           2: d[i] = -1;
                           default: d[i] = 0;
                       endcase
                    default: d[i] = base;
                endcase
            end
            vr = mk(d);
            lr = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            offer(vr, lr);
            wait_result(vr, lr);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                if (!out_ready) check("stall_class", longint'(out_class), ref_class(vr));
            end
            handshake();
        end

        // Reset four cycles into a scan
        for (int i = 0; i < CH; i++) d[i] = (i == 5) ? 9 : 0;
        offer(mk(d), 1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_ready", longint'(in_ready), 1);
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_class", longint'(out_class), 0);
        check("mid_rst_last", longint'(out_last), 0);
        check("mid_rst_count", longint'(out_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_count = 0; exp_count2 = 0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_result_after_rst", seen, 0);
        d = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        run_beat(mk(d), 1'b0);

        // Enough beats for the 4-bit counter to wrap
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < CH; i++) d[i] = int'($urandom_range(0, 20)) - 10;
            run_beat(mk(d), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
